// File: rtl/intr_cpu_agent_if.sv
// Bus-side bundle between INTR_CTRL and its processor agent.
// master: agent side; slave: controller side.
interface intr_cpu_agent_if;
    logic       intr_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_drv;
    logic       intr_in;

    modport master (
        input  intr_out, bus_oe, bus_in,
        output bus_out, bus_drv, intr_in
    );

    modport slave (
        output intr_out, bus_oe, bus_in,
        input  bus_out, bus_drv, intr_in
    );
endinterface

// File: rtl/intr_cpu_agent.sv
// Processor-side responder for INTR_CTRL: programs the controller,
// runs ack/vector/ack/ISR/EOI and hands each vector to a host ISR port.
// Ports: clk, rst_in (async, active low), bus (intr_cpu_agent_if.master),
//   cfg_mode/cfg_prio/cfg_start/cfg_done (programming),
//   isr_req/isr_id/isr_done (host ISR port), vec_err (sticky).
// Option: define INTR_VEC_CHECK_EN to validate the vector prefix.
module intr_cpu_agent #(
    parameter int ACK_DELAY  = 6,
    parameter int ADDR_DELAY = 6
) (
    input  logic                   clk,
    input  logic                   rst_in,
    intr_cpu_agent_if.master       bus,
    input  logic                   cfg_mode,
    input  logic [23:0]            cfg_prio,
    input  logic                   cfg_start,
    output logic                   cfg_done,
    output logic                   isr_req,
    output logic [2:0]             isr_id,
    input  logic                   isr_done,
    output logic                   vec_err
);

    typedef enum logic [3:0] {
        IDLE, CFG, WAIT_INT, ACK_DLY, ACK1,
        CAPTURE, ADDR_DLY, ACK2, ISR, EOI
    } state_t;

    localparam logic [3:0] ACK_LD  = 4'(ACK_DELAY - 1);
    localparam logic [3:0] ADDR_LD = 4'(ADDR_DELAY - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        mode;
    logic [23:0] prio;
    logic        lat_cfg, set_done, set_err, cap;
    logic        vec_ok;

`ifdef INTR_VEC_CHECK_EN
    assign vec_ok = bus.bus_in[7:3] == (mode ? 5'b10011 : 5'b01011);
`else
    assign vec_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            mode     <= 1'b0;
            prio     <= '0;
            cfg_done <= 1'b0;
            isr_id   <= '0;
            vec_err  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (lat_cfg) begin
                mode <= cfg_mode;
                prio <= cfg_prio;
            end
            if (set_done) cfg_done <= 1'b1;
            if (cap)      isr_id   <= bus.bus_in[2:0];
            if (set_err)  vec_err  <= 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lat_cfg  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    lat_cfg = 1'b1;
                    cnt_n   = '0;
                    state_n = CFG;
                end
            end
            CFG: begin
                // polling sends one byte, priority sends four
                if (!mode || cnt == 4'd3) begin
                    set_done = 1'b1;
                    state_n  = WAIT_INT;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            WAIT_INT: begin
                if (bus.intr_out) begin
                    cnt_n   = ACK_LD;
                    state_n = ACK_DLY;
                end
            end
            ACK_DLY: begin
                if (!bus.intr_out) begin
                    state_n = WAIT_INT;
                end else if (cnt == 4'd0) begin
                    state_n = ACK1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACK1: begin
                cnt_n   = '0;
                state_n = CAPTURE;
            end
            CAPTURE: begin
                if (bus.bus_oe) begin
                    cap = 1'b1;
                    if (vec_ok) begin
                        cnt_n   = ADDR_LD;
                        state_n = ADDR_DLY;
                    end else begin
                        set_err = 1'b1;
                        state_n = WAIT_INT;
                    end
                end else if (cnt == 4'd3) begin
                    // controller never drove the vector
                    set_err = 1'b1;
                    state_n = WAIT_INT;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ADDR_DLY: begin
                if (cnt == 4'd0) begin
                    state_n = ACK2;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACK2: state_n = ISR;
            ISR: begin
                if (isr_done) state_n = EOI;
            end
            EOI: state_n = WAIT_INT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_out = '0;
        if (cfg_done) bus.bus_out = {7'd0, ~mode};
        unique case (state)
            CFG: begin
                if (!mode) begin
                    bus.bus_out = 8'h01;
                end else begin
                    unique case (cnt[1:0])
                        2'd0: bus.bus_out = {prio[23:18], 2'b10};
                        2'd1: bus.bus_out = {prio[17:12], 2'b10};
                        2'd2: bus.bus_out = {prio[11:6], 2'b10};
                        default: bus.bus_out = {prio[5:0], 2'b10};
                    endcase
                end
            end
            EOI: begin
                bus.bus_out = mode ? {5'b01100, isr_id}
                                   : {5'b10100, isr_id};
            end
            default: ;
        endcase
    end

    assign bus.intr_in = !(state == ACK1 || state == ACK2 ||
                           state == EOI);
    assign bus.bus_drv = ~bus.bus_oe;
    assign isr_req     = state == ISR;

endmodule

// File: tb/tb_intr_cpu_agent.sv
// Self-checking bench for intr_cpu_agent: acts as INTR_CTRL and host,
// with a reference model of bytes, latencies and service order.
module tb_intr_cpu_agent;

    localparam int ACK_DELAY  = 6;
    localparam int ADDR_DELAY = 6;
`ifdef INTR_VEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cfg_mode;
    logic [23:0] cfg_prio;
    logic        cfg_start;
    logic        cfg_done;
    logic        isr_req;
    logic [2:0]  isr_id;
    logic        isr_done;
    logic        vec_err;

    intr_cpu_agent_if bus();

    intr_cpu_agent #(.ACK_DELAY(ACK_DELAY), .ADDR_DELAY(ADDR_DELAY)) dut (
        .clk(clk), .rst_in(rst_in), .bus(bus),
        .cfg_mode(cfg_mode), .cfg_prio(cfg_prio),
        .cfg_start(cfg_start), .cfg_done(cfg_done),
        .isr_req(isr_req), .isr_id(isr_id),
        .isr_done(isr_done), .vec_err(vec_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic m_mode;
    logic m_err;
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];

    function automatic logic [7:0] eoi_byte(input logic m,
                                            input logic [2:0] id);
        return {(m ? 5'b01100 : 5'b10100), id};
    endfunction

    function automatic logic [7:0] idle_byte(input logic m);
        return m ? 8'h00 : 8'h01;
    endfunction

    function automatic logic vec_valid(input logic m,
                                       input logic [7:0] v);
        if (!CHK) return 1'b1;
        return v[7:3] == (m ? 5'b10011 : 5'b01011);
    endfunction

    function automatic logic [7:0] rand_vec(input logic m);
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 3) != 0)
            v[7:3] = m ? 5'b10011 : 5'b01011;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_in = 1'b0;
        cfg_start = 1'b0;
        cfg_mode = 1'b0;
        cfg_prio = '0;
        isr_done = 1'b0;
        bus.intr_out = 1'b0;
        bus.bus_oe = 1'b0;
        bus.bus_in = '0;
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        m_err = 1'b0;
    endtask

    task automatic test_reset;
        logic [14:0] got, exp;
        do_reset();
        got = {bus.intr_in, bus.bus_out, isr_req, vec_err,
               cfg_done, isr_id};
        exp = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, exp);
        end
        checks++;
        if (bus.bus_drv !== 1'b1) begin
            errors++;
            $display("FAIL reset_bus_drv got=%b want=1", bus.bus_drv);
        end
    endtask

    task automatic configure(input logic m, input logic [23:0] p);
        logic [7:0] bytes[$];
        logic [2:0] pid[8];
        for (int i = 0; i < 8; i++) pid[i] = p[23 - 3*i -: 3];
        if (!m) bytes.push_back(8'h01);
        else
            for (int k = 0; k < 4; k++)
                bytes.push_back({pid[2*k], pid[2*k+1], 2'b10});
        cfg_mode = m;
        cfg_prio = p;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_mode = ~m;
        cfg_prio = 24'($urandom);
        foreach (bytes[i]) begin
            checks++;
            if (bus.bus_out !== bytes[i] || cfg_done !== 1'b0) begin
                errors++;
                $display("FAIL cfg_byte%0d got=%h done=%b want=%h",
                         i, bus.bus_out, cfg_done, bytes[i]);
            end
            tick();
        end
        checks++;
        if (cfg_done !== 1'b1 || bus.bus_out !== idle_byte(m)) begin
            errors++;
            $display("FAIL cfg_exit done=%b bus=%h want=1/%h",
                     cfg_done, bus.bus_out, idle_byte(m));
        end
        m_mode = m;
    endtask

    task automatic service(input logic [7:0] v, input int hold);
        int n;
        int lows;
        bus.intr_out = 1'b1;
        n = 0;
        while (bus.intr_in !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != ACK_DELAY + 1) begin
            errors++;
            $display("FAIL ack1_latency got=%0d want=%0d",
                     n, ACK_DELAY + 1);
        end
        bus.intr_out = 1'b0;
        bus.bus_oe = 1'b1;
        bus.bus_in = v;
        #1;
        checks++;
        if (bus.bus_drv !== 1'b0) begin
            errors++;
            $display("FAIL bus_drv got=%b want=0", bus.bus_drv);
        end
        tick();
        tick();
        bus.bus_oe = 1'b0;
        bus.bus_in = 8'($urandom);
        if (vec_valid(m_mode, v)) begin
            exp_q.push_back(v[2:0]);
            n = 0;
            while (bus.intr_in !== 1'b0 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            if (n != ADDR_DELAY) begin
                errors++;
                $display("FAIL ack2_latency got=%0d want=%0d",
                         n, ADDR_DELAY);
            end
            tick();
            got_q.push_back(isr_id);
            checks++;
            if (isr_req !== 1'b1 || isr_id !== v[2:0] ||
                bus.intr_in !== 1'b1) begin
                errors++;
                $display("FAIL isr_enter req=%b id=%0d want=1/%0d",
                         isr_req, isr_id, v[2:0]);
            end
            repeat (hold) tick();
            checks++;
            if (isr_req !== 1'b1) begin
                errors++;
                $display("FAIL isr_hold req=%b want=1", isr_req);
            end
            isr_done = 1'b1;
            tick();
            isr_done = 1'b0;
            checks++;
            if (isr_req !== 1'b0 || bus.intr_in !== 1'b0 ||
                bus.bus_out !== eoi_byte(m_mode, v[2:0])) begin
                errors++;
                $display("FAIL eoi req=%b intr_in=%b bus=%h want=0/0/%h",
                         isr_req, bus.intr_in, bus.bus_out,
                         eoi_byte(m_mode, v[2:0]));
            end
            tick();
            checks++;
            if (bus.intr_in !== 1'b1 ||
                bus.bus_out !== idle_byte(m_mode) ||
                vec_err !== m_err) begin
                errors++;
                $display("FAIL eoi_exit intr_in=%b bus=%h err=%b want=1/%h/%b",
                         bus.intr_in, bus.bus_out, vec_err,
                         idle_byte(m_mode), m_err);
            end
        end else begin
            m_err = 1'b1;
            lows = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus.intr_in !== 1'b1 || isr_req !== 1'b0) lows++;
                tick();
            end
            checks++;
            if (vec_err !== 1'b1 || lows != 0 ||
                bus.bus_out !== idle_byte(m_mode)) begin
                errors++;
                $display("FAIL bad_vec err=%b strobes=%0d bus=%h want=1/0/%h",
                         vec_err, lows, bus.bus_out, idle_byte(m_mode));
            end
        end
    endtask

    task automatic check_order(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d want=%0d",
                     tag, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_order%0d got=%0d want=%0d",
                             tag, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_polling_cfg;
        configure(1'b0, 24'($urandom));
    endtask

    task automatic test_polling_service;
        service(8'h5D, 3);
        for (int i = 0; i < 5; i++)
            service(rand_vec(1'b0), int'($urandom_range(0, 5)));
        check_order("poll");
    endtask

    task automatic test_bad_vector;
        service(8'hFF, 1);
        check_order("bad");
    endtask

    task automatic test_cfg_ignored;
        isr_done = 1'b1;
        cfg_mode = ~m_mode;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        isr_done = 1'b0;
        tick();
        checks++;
        if (bus.bus_out !== idle_byte(m_mode) || cfg_done !== 1'b1 ||
            bus.intr_in !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ignored bus=%h done=%b want=%h/1",
                     bus.bus_out, cfg_done, idle_byte(m_mode));
        end
    endtask

    task automatic test_spurious;
        int lows;
        bus.intr_out = 1'b1;
        repeat (3) tick();
        bus.intr_out = 1'b0;
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.intr_in !== 1'b1) lows++;
            tick();
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL spurious_ack got=%0d want=0", lows);
        end
        service(rand_vec(m_mode), 2);
        check_order("spur");
    endtask

    task automatic test_timeout;
        int n;
        bus.intr_out = 1'b1;
        n = 0;
        while (bus.intr_in !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        bus.intr_out = 1'b0;
        repeat (4) tick();
        checks++;
        if (vec_err !== m_err) begin
            errors++;
            $display("FAIL timeout_early got=%b want=%b", vec_err, m_err);
        end
        tick();
        m_err = 1'b1;
        checks++;
        if (vec_err !== 1'b1 || isr_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got=%b req=%b want=1/0",
                     vec_err, isr_req);
        end
    endtask

    task automatic test_abort;
        int n;
        int lows;
        do_reset();
        configure(1'b0, 24'($urandom));
        bus.intr_out = 1'b1;
        n = 0;
        while (bus.intr_in !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        bus.intr_out = 1'b0;
        bus.bus_oe = 1'b1;
        bus.bus_in = 8'h5D;
        tick();
        tick();
        bus.bus_oe = 1'b0;
        n = 0;
        while (isr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (isr_req !== 1'b0 || bus.intr_in !== 1'b1 ||
            bus.bus_out !== 8'h00 || n >= 40) begin
            errors++;
            $display("FAIL abort req=%b intr_in=%b bus=%h wait=%0d",
                     isr_req, bus.intr_in, bus.bus_out, n);
        end
        tick();
        rst_in = 1'b1;
        m_err = 1'b0;
        bus.intr_out = 1'b1;
        lows = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.intr_in !== 1'b1) lows++;
            tick();
        end
        bus.intr_out = 1'b0;
        checks++;
        if (lows != 0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_eoi strobes=%0d done=%b want=0/0",
                     lows, cfg_done);
        end
    endtask

    task automatic test_priority_cfg;
        do_reset();
        configure(1'b1, {3'd5, 3'd3, 3'd7, 3'd0,
                         3'd4, 3'd2, 3'd6, 3'd1});
    endtask

    task automatic test_back_to_back;
        service(8'h9B, 2);
        for (int i = 0; i < 9; i++)
            service(rand_vec(1'b1), int'($urandom_range(0, 4)));
        check_order("b2b");
    endtask

    initial begin
        test_reset();
        test_polling_cfg();
        test_polling_service();
        test_bad_vector();
        test_cfg_ignored();
        test_spurious();
        test_timeout();
        test_abort();
        test_priority_cfg();
        test_back_to_back();
        test_bad_vector();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
